// File: rtl/addsub_nibble_serial_16b.sv
// addsub_nibble_serial_16b
// Multi-cycle WIDTH-bit adder/subtractor built around one SLICE-bit add/sub
// slice. Operands are accepted through a valid/ready handshake. One slice is
// resolved per cycle, with the carry held in a register between slices. The
// result and its flags are presented through a second valid/ready handshake.
// Subtraction is A + ~B + 1: B is inverted per slice and the carry is seeded
// with 1.

module addsub_nibble_serial_16b #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             add_sub_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sub_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [WIDTH-1:0]   out_r;
    logic               c_out_r;
    logic               ovf_r;
    logic               zero_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [SLICE-1:0]   a_slice_s;
    logic [SLICE-1:0]   b_slice_s;
    logic [SLICE:0]     slice_sum_s;
    logic [SLICE-1:0]   s_slice_s;
    logic               cy_s;
    logic               msb_cin_s;
    logic               last_slice_s;
    logic [WIDTH-1:0]   out_next_s;

    // One slice of the add/sub: select slice cnt, condition B, add with the carry.
    always_comb begin
        a_slice_s    = a_r[int'(cnt_r)*SLICE +: SLICE];
        b_slice_s    = b_r[int'(cnt_r)*SLICE +: SLICE] ^ {SLICE{sub_r}};
        slice_sum_s  = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{SLICE{1'b0}}, carry_r};
        s_slice_s    = slice_sum_s[SLICE-1:0];
        cy_s         = slice_sum_s[SLICE];
        // The carry into the slice's top bit is recovered from that bit's sum:
        // s = a ^ b ^ cin.
        msb_cin_s    = a_slice_s[SLICE-1] ^ b_slice_s[SLICE-1] ^ s_slice_s[SLICE-1];
        out_next_s   = out_r;
        out_next_s[int'(cnt_r)*SLICE +: SLICE] = s_slice_s;
        last_slice_s = (cnt_r == CNT_W'(NSLICE - 1));
    end

    // Next-state logic for the IDLE -> RUN -> DONE operation sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered handshake outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, per-slice accumulation and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= inA;
                        b_r     <= inB;
                        sub_r   <= add_sub_sel;
                        carry_r <= add_sub_sel;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    out_r   <= out_next_s;
                    carry_r <= cy_s;
                    if (last_slice_s) begin
                        c_out_r <= cy_s;
                        ovf_r   <= msb_cin_s ^ cy_s;
                        zero_r  <= (out_next_s == {WIDTH{1'b0}});
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_addsub_nibble_serial_16b.sv
// Self-checking bench for addsub_nibble_serial_16b: directed corner cases,
// output-hold and reset-abort scenarios, then randomized operations against
// an arithmetic reference model.

module tb_addsub_nibble_serial_16b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        add_sub_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_w;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    addsub_nibble_serial_16b #(.WIDTH(16), .SLICE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inA         (inA),
        .inB         (inB),
        .add_sub_sel (add_sub_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out_w),
        .c_out       (c_out),
        .ovf         (ovf),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned and signed arithmetic.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sel,
                         output logic [15:0] r, output logic c, output logic v, output logic z);
        logic [16:0] full;
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sel) begin
            full = {1'b0, a} + 17'h10000 - {1'b0, b};
            sr   = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            sr   = sa + sb;
        end
        r = full[15:0];
        c = full[16];
        v = (sr > 32767) || (sr < -32768);
        z = (r == 16'h0000);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sel,
                          input logic [15:0] er, input logic ec, input logic ev, input logic ez,
                          input int in_dly, input int out_dly, input bit noise);
        int wait_cnt;
        int lat;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (in_dly) step();
        inA = a;
        inB = b;
        add_sub_sel = sel;
        in_valid = 1'b1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
            inA = 16'($urandom);
            inB = 16'($urandom);
            add_sub_sel = 1'($urandom_range(0, 1));
        end
        check_val("in_ready_run", {31'd0, in_ready}, 32'd0);
        check_val("out_valid_run", {31'd0, out_valid}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
        end
        out_ready = 1'b0;
        check_val("latency", lat, 32'd4);
        check_val("out", {16'd0, out_w}, {16'd0, er});
        check_val("c_out", {31'd0, c_out}, {31'd0, ec});
        check_val("ovf", {31'd0, ovf}, {31'd0, ev});
        check_val("zero", {31'd0, zero}, {31'd0, ez});
        repeat (out_dly) begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("hold_out", {13'd0, out_w, c_out, ovf, zero}, {13'd0, er, ec, ev, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("consumed_valid", {31'd0, out_valid}, 32'd0);
        check_val("consumed_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("idle_hold_out", {13'd0, out_w, c_out, ovf, zero}, {13'd0, er, ec, ev, ez});
    endtask

    initial begin
        logic [15:0] ra, rb, rr;
        logic rs, rc, rv, rz;
        int wait_cnt;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        inA = 16'h0000;
        inB = 16'h0000;
        add_sub_sel = 1'b0;
        #12;
        check_val("rst_outs", {12'd0, out_w, c_out, ovf, zero, out_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #5;
        rst_n = 1'b1;
        step();

        // Directed corner cases.
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1, 0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1, 0);
        run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 2, 0, 0);
        run_op(16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        // Long stall in DONE with stray in_valid pulses.
        run_op(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0, 0, 10, 1);

        // Reset two cycles into RUN.
        inA = 16'hDEAD;
        inB = 16'hBEEF;
        add_sub_sel = 1'b0;
        in_valid = 1'b1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        check_val("rst_test_accept", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_val("abort_outs", {12'd0, out_w, c_out, ovf, zero, out_valid}, 32'd0);
        check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        step();
        run_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 16 == 0) rb = ra;
            if (i % 16 == 1) rb = 16'h0000 - ra;
            model(ra, rb, rs, rr, rc, rv, rz);
            run_op(ra, rb, rs, rr, rc, rv, rz, $urandom_range(0, 2), $urandom_range(0, 3), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
